// File: rtl/fpu_pkg.sv
// Shared constants and types for the single-precision divide issue stage.
//   QNAN / POS_INF / EXP_BIAS : IEEE-754 single constants
//   FLG_*                     : bit positions inside the 5-bit result flag vector
//   ST_*                      : issue FSM state encoding
//   fp_class_t                : per-operand classification bundle
package fpu_pkg;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam int          EXP_BIAS = 127;

  // out_flags = {invalid, divzero, overflow, underflow, timeout}
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_TIMEOUT   = 0;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLASSIFY = 3'd1;
  localparam logic [2:0] ST_LAUNCH   = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;  // exponent field zero: denormals are treated as zero
  } fp_class_t;

endpackage

// File: rtl/fpu_fdiv_issue_if.sv
// Handshake and divider bus of the divide issue stage.
//   in_*      : operand pair from the producer (valid/ready)
//   div_*     : launch/completion link to the iterative divider
//   out_*     : packed result and flags to the consumer (valid/ready)
// Modports: slave = the issue stage, master = the surrounding parent.
interface fpu_fdiv_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic        div_valid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [4:0]  out_flags;

  modport slave (
    input  in_valid, in_a, in_b, div_q, div_valid, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_q, out_flags
  );

  modport master (
    output in_valid, in_a, in_b, div_q, div_valid, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_q, out_flags
  );
endinterface

// File: rtl/fpu_classify.sv
// Combinational classification of one IEEE-754 single operand.
//   i_op  : exponent and fraction fields (sign is irrelevant here)
//   o_cls : {nan, inf, zero}
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [30:0] i_op,
  output fp_class_t   o_cls
);

  logic w_exp_max;
  logic w_exp_zero;
  logic w_frac_zero;

  assign w_exp_max   = &i_op[30:23];
  assign w_exp_zero  = ~|i_op[30:23];
  assign w_frac_zero = ~|i_op[22:0];

  assign o_cls.nan  = w_exp_max & ~w_frac_zero;
  assign o_cls.inf  = w_exp_max & w_frac_zero;
  assign o_cls.zero = w_exp_zero;

endmodule

// File: rtl/fpu_fdiv_issue.sv
// Issue/completion stage around the iterative single-precision divider.
// Special operand pairs are answered directly; the rest launch the divider
// and the quotient fraction is packed with a locally computed sign/exponent.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fpu_fdiv_issue_if (in_*, div_*, out_*)
//
// state    | meaning
// IDLE     | in_ready high, waiting for an operand pair
// CLASSIFY | captured operands classified, special result or divider path
// LAUNCH   | one-cycle div_start pulse, timeout counter loaded
// WAIT     | waiting for div_valid or timeout
// RESP     | out_valid high, result held until out_ready
module fpu_fdiv_issue
  import fpu_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
)(
  input  logic              clk,
  input  logic              rst,
  fpu_fdiv_issue_if.slave   bus
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  logic [2:0]       r_state;
  logic [31:0]      r_div_a;
  logic [31:0]      r_div_b;
  logic [31:0]      r_out_q;
  logic [4:0]       r_out_flags;
  logic             r_sign;
  logic [7:0]       r_exp;
  logic [CNT_W-1:0] r_cnt;

  fp_class_t   w_cls_a;
  fp_class_t   w_cls_b;
  logic        w_sign;
  logic        w_frac_lt;
  logic [9:0]  w_e;
  logic        w_special;
  logic [31:0] w_sp_q;
  logic [4:0]  w_sp_flags;

  fpu_classify u_cls_a (.i_op(r_div_a[30:0]), .o_cls(w_cls_a));
  fpu_classify u_cls_b (.i_op(r_div_b[30:0]), .o_cls(w_cls_b));

  assign w_sign    = r_div_a[31] ^ r_div_b[31];
  assign w_frac_lt = (r_div_a[22:0] < r_div_b[22:0]);
  // Two's-complement 10-bit exponent; bit 9 set means negative.
  assign w_e = {2'b00, r_div_a[30:23]} - {2'b00, r_div_b[30:23]}
             + 10'(EXP_BIAS) - {9'd0, w_frac_lt};

  always_comb begin
    w_special  = 1'b1;
    w_sp_q     = QNAN;
    w_sp_flags = '0;
    if (w_cls_a.nan || w_cls_b.nan) begin
      w_sp_flags[FLG_INVALID] = 1'b1;
    end else if ((w_cls_a.zero && w_cls_b.zero) || (w_cls_a.inf && w_cls_b.inf)) begin
      w_sp_flags[FLG_INVALID] = 1'b1;
    end else if (w_cls_a.inf) begin
      w_sp_q = {w_sign, POS_INF[30:0]};
    end else if (w_cls_b.zero) begin
      w_sp_q = {w_sign, POS_INF[30:0]};
      w_sp_flags[FLG_DIVZERO] = 1'b1;
    end else if (w_cls_a.zero || w_cls_b.inf) begin
      w_sp_q = {w_sign, 31'd0};
    end else if (!w_e[9] && (w_e >= 10'd255)) begin
      w_sp_q = {w_sign, POS_INF[30:0]};
      w_sp_flags[FLG_OVERFLOW] = 1'b1;
    end else if (w_e[9] || (w_e == 10'd0)) begin
      w_sp_q = {w_sign, 31'd0};
      w_sp_flags[FLG_UNDERFLOW] = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_out_q     <= '0;
      r_out_flags <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_div_a <= bus.in_a;
            r_div_b <= bus.in_b;
            r_state <= ST_CLASSIFY;
          end
        end
        ST_CLASSIFY: begin
          if (w_special) begin
            r_out_q     <= w_sp_q;
            r_out_flags <= w_sp_flags;
            r_state     <= ST_RESP;
          end else begin
            r_sign  <= w_sign;
            r_exp   <= w_e[7:0];
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // Down-counter: DIV_TIMEOUT WAIT cycles end at terminal count 0.
          r_cnt   <= CNT_W'(DIV_TIMEOUT - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.div_valid) begin
            r_out_q     <= {r_sign, r_exp, bus.div_q[22:0]};
            r_out_flags <= '0;
            r_state     <= ST_RESP;
          end else if (r_cnt == '0) begin
            r_out_q                  <= QNAN;
            r_out_flags              <= '0;
            r_out_flags[FLG_TIMEOUT] <= 1'b1;
            r_state                  <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.div_start = (r_state == ST_LAUNCH);
  assign bus.out_valid = (r_state == ST_RESP);
  assign bus.div_a     = r_div_a;
  assign bus.div_b     = r_div_b;
  assign bus.out_q     = r_out_q;
  assign bus.out_flags = r_out_flags;

endmodule
